// File: rtl/indicator_shift_out.sv
// indicator_shift_out: takes indicator arrays over valid/ready and shifts them MSB first
// into a 74HC595-style LED chain, then commits them with a latch pulse.
// Optional feature macro: INDICATOR_SHIFT_OUT_SKIP_UNCHANGED_EN. When it is defined, an
// array equal to the last latched one is consumed without any serial activity.
module indicator_shift_out #(
   parameter int unsigned width   = 32,
   parameter int unsigned clk_div = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [width-1:0] i_array,
   output logic             sr_clk,
   output logic             sr_data,
   output logic             sr_latch,
   output logic             busy
);

   localparam int unsigned CNT_W = (width > 1) ? $clog2(width) : 1;
   localparam int unsigned DIV_W = $clog2(clk_div + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(clk_div - 1);
   localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(width - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CLK_LO = 2'd1,
      S_CLK_HI = 2'd2,
      S_LATCH  = 2'd3
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [DIV_W-1:0] r_div, w_div_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [width-1:0] r_shreg, w_shreg_nxt;
   logic             r_ready, w_ready_nxt;
   logic             r_sclk, w_sclk_nxt;
   logic             r_data, w_data_nxt;
   logic             r_latch, w_latch_nxt;
   logic             r_busy, w_busy_nxt;
   logic             w_div_done;
   logic             w_skip;

`ifdef INDICATOR_SHIFT_OUT_SKIP_UNCHANGED_EN
   logic [width-1:0] r_last, w_last_nxt;

   // An array equal to what the LEDs already show needs no shifting.
   assign w_skip = (i_array == r_last);
`else
   assign w_skip = 1'b0;
`endif

   assign w_div_done = (r_div == DIV_LAST);

   // State, counters, shift register and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_div   <= '0;
         r_cnt   <= '0;
         r_shreg <= '0;
         r_ready <= 1'b0;
         r_sclk  <= 1'b0;
         r_data  <= 1'b0;
         r_latch <= 1'b0;
         r_busy  <= 1'b0;
`ifdef INDICATOR_SHIFT_OUT_SKIP_UNCHANGED_EN
         r_last  <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_div   <= w_div_nxt;
         r_cnt   <= w_cnt_nxt;
         r_shreg <= w_shreg_nxt;
         r_ready <= w_ready_nxt;
         r_sclk  <= w_sclk_nxt;
         r_data  <= w_data_nxt;
         r_latch <= w_latch_nxt;
         r_busy  <= w_busy_nxt;
`ifdef INDICATOR_SHIFT_OUT_SKIP_UNCHANGED_EN
         r_last  <= w_last_nxt;
`endif
      end
   end

   // Next-state and next-output logic; the divider restarts on every state change.
   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = r_div;
      w_cnt_nxt   = r_cnt;
      w_shreg_nxt = r_shreg;
      w_data_nxt  = r_data;
`ifdef INDICATOR_SHIFT_OUT_SKIP_UNCHANGED_EN
      w_last_nxt  = r_last;
`endif
      case (r_state)
         S_IDLE: begin
            w_div_nxt = '0;
            if (i_valid && r_ready && !w_skip) begin
               w_shreg_nxt = i_array;
               w_cnt_nxt   = CNT_TOP;
               w_data_nxt  = i_array[width-1];
               w_state_nxt = S_CLK_LO;
            end
         end
         S_CLK_LO: begin
            if (w_div_done) begin
               w_div_nxt   = '0;
               w_state_nxt = S_CLK_HI;
            end else begin
               w_div_nxt = r_div + 1'b1;
            end
         end
         S_CLK_HI: begin
            if (w_div_done) begin
               w_div_nxt = '0;
               if (r_cnt == '0) begin
                  w_data_nxt  = 1'b0;
                  w_state_nxt = S_LATCH;
`ifdef INDICATOR_SHIFT_OUT_SKIP_UNCHANGED_EN
                  w_last_nxt  = r_shreg;
`endif
               end else begin
                  w_cnt_nxt   = r_cnt - 1'b1;
                  w_data_nxt  = r_shreg[w_cnt_nxt];
                  w_state_nxt = S_CLK_LO;
               end
            end else begin
               w_div_nxt = r_div + 1'b1;
            end
         end
         S_LATCH: begin
            if (w_div_done) begin
               w_div_nxt   = '0;
               w_state_nxt = S_IDLE;
            end else begin
               w_div_nxt = r_div + 1'b1;
            end
         end
         default: begin
            w_div_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
      w_ready_nxt = (w_state_nxt == S_IDLE);
      w_busy_nxt  = (w_state_nxt != S_IDLE);
      w_sclk_nxt  = (w_state_nxt == S_CLK_HI);
      w_latch_nxt = (w_state_nxt == S_LATCH);
   end

   assign i_ready  = r_ready;
   assign sr_clk   = r_sclk;
   assign sr_data  = r_data;
   assign sr_latch = r_latch;
   assign busy     = r_busy;

endmodule

// File: tb/tb_indicator_shift_out.sv
// tb_indicator_shift_out: random and directed frames checked against a timing/bit model.
module tb_indicator_shift_out;

   localparam int unsigned W   = 32;
   localparam int unsigned CD0 = 2;
   localparam int unsigned CD1 = 1;
`ifdef INDICATOR_SHIFT_OUT_SKIP_UNCHANGED_EN
   localparam bit SKIP_EN = 1'b1;
`else
   localparam bit SKIP_EN = 1'b0;
`endif

   logic         clk   = 1'b0;
   logic         reset = 1'b0;
   logic         v0 = 1'b0, v1 = 1'b0;
   logic [W-1:0] a0 = '0, a1 = '0;
   logic         rdy0, rdy1, sc0, sc1, sd0, sd1, sl0, sl1, bz0, bz1;

   always #5 clk = ~clk;

   indicator_shift_out #(.width(W), .clk_div(CD0)) u_dut0 (
      .clk(clk), .reset(reset), .i_valid(v0), .i_ready(rdy0), .i_array(a0),
      .sr_clk(sc0), .sr_data(sd0), .sr_latch(sl0), .busy(bz0));

   indicator_shift_out #(.width(W), .clk_div(CD1)) u_dut1 (
      .clk(clk), .reset(reset), .i_valid(v1), .i_ready(rdy1), .i_array(a1),
      .sr_clk(sc1), .sr_data(sd1), .sr_latch(sl1), .busy(bz1));

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;
   int unsigned cyc    = 0;
   int          sel    = 0;
   logic [W-1:0] m_last [2];

   always @(posedge clk) cyc <= cyc + 1;

   // Observed serial activity of the selected DUT.
   logic        w_sc, w_sd, w_sl, w_rdy;
   logic        p_sc = 1'b0, p_sl = 1'b0, p_rdy = 1'b0;
   int unsigned lat_run = 0;
   int unsigned rise_t [$];
   logic        rise_b [$];
   int unsigned lat_t [$];
   int unsigned lat_w [$];
   int unsigned rdy_t [$];

   assign w_sc  = (sel == 1) ? sc1  : sc0;
   assign w_sd  = (sel == 1) ? sd1  : sd0;
   assign w_sl  = (sel == 1) ? sl1  : sl0;
   assign w_rdy = (sel == 1) ? rdy1 : rdy0;

   always @(negedge clk) begin
      if (w_sc && !p_sc) begin
         rise_t.push_back(cyc);
         rise_b.push_back(w_sd);
      end
      if (w_sl && !p_sl) lat_t.push_back(cyc);
      if (w_sl) lat_run = lat_run + 1;
      else if (p_sl) begin
         lat_w.push_back(lat_run);
         lat_run = 0;
      end
      if (w_rdy && !p_rdy) rdy_t.push_back(cyc);
      p_sc  = w_sc;
      p_sl  = w_sl;
      p_rdy = w_rdy;
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clr();
      rise_t.delete(); rise_b.delete(); lat_t.delete(); lat_w.delete(); rdy_t.delete();
   endtask

   function automatic bit will_skip(input int d, input logic [W-1:0] a);
      return SKIP_EN && (a == m_last[d]);
   endfunction

   // Present an array and return the acceptance cycle T (valid kept high if keep=1).
   task automatic send(input int d, input logic [W-1:0] a, input bit keep, output int unsigned t);
      int unsigned n = 0;
      if (d == 0) begin v0 = 1'b1; a0 = a; end
      else        begin v1 = 1'b1; a1 = a; end
      while (!((d == 0) ? rdy0 : rdy1) && n < 2000) begin
         tick();
         n++;
      end
      chk("accept_timeout", 64'(n < 2000), 64'd1);
      t = cyc;
      tick();
      if (!keep) begin
         if (d == 0) v0 = 1'b0;
         else        v1 = 1'b0;
      end
   endtask

   // Compare one complete frame against the arithmetic timing/bit model.
   task automatic check_frame(input int unsigned cd, input logic [W-1:0] a, input int unsigned t);
      int unsigned endc = t + 1 + (2 * W + 1) * cd;
      int unsigned rt;
      logic        rb;
      while (cyc < endc + 1) tick();
      chk("rise_count", 64'(rise_t.size() >= W), 64'd1);
      for (int k = 0; k < int'(W); k++) begin
         if (rise_t.size() == 0) break;
         rt = rise_t.pop_front();
         rb = rise_b.pop_front();
         chk($sformatf("rise_time_k%0d", k), 64'(rt), 64'(t + 1 + cd * (2 * k + 1)));
         chk($sformatf("bit_k%0d", k), 64'(rb), 64'(a[W-1-k]));
      end
      chk("latch_count", 64'(lat_t.size()), 64'd1);
      if (lat_t.size() > 0) chk("latch_start", 64'(lat_t.pop_front()), 64'(t + 1 + 2 * W * cd));
      if (lat_w.size() > 0) chk("latch_width", 64'(lat_w.pop_front()), 64'(cd));
      chk("ready_count", 64'(rdy_t.size() > 0), 64'd1);
      if (rdy_t.size() > 0) chk("ready_return", 64'(rdy_t.pop_front()), 64'(endc));
   endtask

   task automatic check_skip(input int d, input int unsigned cd);
      chk("skip_ready", 64'((d == 0) ? rdy0 : rdy1), 64'd1);
      chk("skip_busy", 64'((d == 0) ? bz0 : bz1), 64'd0);
      repeat (2 * cd + 4) tick();
      chk("skip_rises", 64'(rise_t.size()), 64'd0);
      chk("skip_latch", 64'(lat_t.size()), 64'd0);
   endtask

   task automatic do_frame(input int d, input logic [W-1:0] a);
      int unsigned t;
      int unsigned cd = (d == 0) ? CD0 : CD1;
      bit          sk = will_skip(d, a);
      send(d, a, 1'b0, t);
      if (sk) check_skip(d, cd);
      else begin
         check_frame(cd, a, t);
         m_last[d] = a;
      end
   endtask

   initial begin
      int unsigned  t1, t2, n;
      logic [W-1:0] ra;
      m_last[0] = '0;
      m_last[1] = '0;

      // Reset values, then ready one clock after release.
      repeat (3) tick();
      chk("rst_ready", 64'(rdy0), 64'd0);
      chk("rst_sclk", 64'(sc0), 64'd0);
      chk("rst_sdata", 64'(sd0), 64'd0);
      chk("rst_latch", 64'(sl0), 64'd0);
      chk("rst_busy", 64'(bz0), 64'd0);
      reset = 1'b1;
      tick();
      chk("ready_after_release", 64'(rdy0), 64'd1);
      tick();
      clr();

      // Single frame.
      do_frame(0, 32'h8000_0001);

      // Back-to-back with valid held high.
      send(0, 32'hFFFF_FFFF, 1'b1, t1);
      send(0, 32'h0000_0000, 1'b0, t2);
      chk("b2b_gap", 64'(t2 - t1), 64'((2 * W + 1) * CD0 + 1));
      check_frame(CD0, 32'hFFFF_FFFF, t1);
      check_frame(CD0, 32'h0000_0000, t2);
      m_last[0] = '0;

      // Valid pulsed while busy is ignored.
      ra = $urandom;
      if (will_skip(0, ra)) ra = ~ra;
      send(0, ra, 1'b0, t1);
      repeat (20) tick();
      v0 = 1'b1;
      a0 = ~ra;
      repeat (5) begin
         chk("busy_ready_low", 64'(rdy0), 64'd0);
         tick();
      end
      v0 = 1'b0;
      check_frame(CD0, ra, t1);
      m_last[0] = ra;
      repeat (5) tick();
      chk("no_capture_busy", 64'(bz0), 64'd0);
      chk("no_capture_rises", 64'(rise_t.size()), 64'd0);

      // Random frames with random idle gaps.
      repeat (6) begin
         repeat ($urandom_range(0, 5)) tick();
         do_frame(0, W'($urandom));
      end

      // Asynchronous reset after bit 10.
      ra = (m_last[0] == 32'hFFFF_FFFF) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;
      send(0, ra, 1'b0, t1);
      n = 0;
      while (rise_t.size() < 11 && n < 500) begin
         tick();
         n++;
      end
      chk("pre_rst_sclk", 64'(sc0), 64'd1);
      chk("pre_rst_busy", 64'(bz0), 64'd1);
      #1 reset = 1'b0;
      #1;
      chk("async_sclk", 64'(sc0), 64'd0);
      chk("async_sdata", 64'(sd0), 64'd0);
      chk("async_latch", 64'(sl0), 64'd0);
      chk("async_busy", 64'(bz0), 64'd0);
      chk("async_ready", 64'(rdy0), 64'd0);
      repeat (2) tick();
      reset = 1'b1;
      m_last[0] = '0;
      m_last[1] = '0;
      repeat (3) tick();
      chk("abort_no_latch", 64'(lat_t.size()), 64'd0);
      clr();
      do_frame(0, 32'hFFFF_FFFF);

      // Fastest divider.
      sel = 1;
      tick();
      clr();
      do_frame(1, 32'hAAAA_AAAA);
      sel = 0;
      tick();
      clr();

`ifdef INDICATOR_SHIFT_OUT_SKIP_UNCHANGED_EN
      // Unchanged array is consumed in one cycle without serial activity.
      do_frame(0, 32'h0000_00FF);
      chk("skip_expected", 64'(will_skip(0, 32'h0000_00FF)), 64'd1);
      do_frame(0, 32'h0000_00FF);
      do_frame(0, 32'h0000_01FF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
